// File: rtl/gnr_node_lut.sv
// Boolean-network node: NUM_COPIES independent copies of one node. Each copy
// updates through a LUT rule, with a per-copy start divider and stability detection.
module gnr_node_lut #(
   parameter int NUM_COPIES = 2,
   parameter int NUM_INPUTS = 3,
   parameter logic [2**NUM_INPUTS-1:0] LUT = 8'hFE,
   parameter int SKIP_W     = 2,
   parameter int STABLE_W   = 4,
   parameter int STABLE_THR = 3
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             reset_nos,
   input  logic [NUM_COPIES-1:0]            init_state,
   input  logic [NUM_COPIES-1:0]            start,
   input  logic [NUM_COPIES*SKIP_W-1:0]     skip,
   input  logic [NUM_COPIES*NUM_INPUTS-1:0] in_states,
   output logic [NUM_COPIES-1:0]            state,
   output logic [NUM_COPIES-1:0]            changed,
   output logic [NUM_COPIES-1:0]            stable
);

   localparam logic [STABLE_W-1:0] STABLE_MAX = '1;
   localparam logic [STABLE_W-1:0] STABLE_LIM = STABLE_W'(STABLE_THR);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_COPIES; gi++) begin : g_copy
         logic [NUM_INPUTS-1:0] lut_idx;
         logic                  state_next;
         logic                  state_reg;
         logic                  changed_reg;
         logic [SKIP_W-1:0]     cnt_reg;
         logic [STABLE_W-1:0]   stable_cnt_reg;

         assign lut_idx    = in_states[gi*NUM_INPUTS +: NUM_INPUTS];
         assign state_next = LUT[lut_idx];

         always_ff @(posedge clk) begin
            if (rst) begin
               state_reg      <= 1'b0;
               changed_reg    <= 1'b0;
               cnt_reg        <= '0;
               stable_cnt_reg <= '0;
            end else if (reset_nos) begin
               state_reg      <= init_state[gi];
               changed_reg    <= 1'b0;
               cnt_reg        <= '0;
               stable_cnt_reg <= '0;
            end else if (start[gi]) begin
               if (cnt_reg == '0) begin
                  // Update: the skip count is captured only here, so a mid-count
                  // change of skip takes effect at the next reload.
                  state_reg   <= state_next;
                  changed_reg <= (state_next != state_reg);
                  cnt_reg     <= skip[gi*SKIP_W +: SKIP_W];
                  if (state_next != state_reg)
                     stable_cnt_reg <= '0;
                  else if (stable_cnt_reg != STABLE_MAX)
                     stable_cnt_reg <= stable_cnt_reg + STABLE_W'(1);
               end else begin
                  changed_reg <= 1'b0;
                  cnt_reg     <= cnt_reg - SKIP_W'(1);
               end
            end else begin
               changed_reg <= 1'b0;
            end
         end

         assign state[gi]   = state_reg;
         assign changed[gi] = changed_reg;
         assign stable[gi]  = (stable_cnt_reg >= STABLE_LIM);
      end
   endgenerate

endmodule

// File: tb/tb_gnr_node_lut.sv
// Directed bench for gnr_node_lut: a table of per-edge vectors on the default
// OR-rule node, plus a hand sequence on an AND-rule instance for stability.
module tb_gnr_node_lut;

   logic       clk = 1'b0;
   logic       rst;
   logic       reset_nos;
   logic [1:0] init_state;
   logic [1:0] start;
   logic [3:0] skip;
   logic [5:0] in_states;
   logic [1:0] state, changed, stable;
   logic [1:0] state_a, changed_a, stable_a;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   gnr_node_lut dut (
      .clk(clk), .rst(rst), .reset_nos(reset_nos), .init_state(init_state),
      .start(start), .skip(skip), .in_states(in_states),
      .state(state), .changed(changed), .stable(stable)
   );

   gnr_node_lut #(.LUT(8'h80)) dut_and (
      .clk(clk), .rst(rst), .reset_nos(reset_nos), .init_state(init_state),
      .start(start), .skip(skip), .in_states(in_states),
      .state(state_a), .changed(changed_a), .stable(stable_a)
   );

   typedef struct {
      logic       rst;
      logic       rn;
      logic [1:0] init;
      logic [1:0] start;
      logic [3:0] skip;
      logic [5:0] ins;
      logic [1:0] exp_state;
      logic [1:0] exp_changed;
      logic [1:0] exp_stable;
   } vec_t;

   vec_t vecs[25];

   task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic rn, input logic [1:0] ini,
                        input logic [1:0] st, input logic [3:0] sk, input logic [5:0] ins);
      rst        = r;
      reset_nos  = rn;
      init_state = ini;
      start      = st;
      skip       = sk;
      in_states  = ins;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset wins over reset_nos and start
      vecs[0]  = '{1'b1, 1'b1, 2'b11, 2'b11, 4'b0000, 6'b000_000, 2'b00, 2'b00, 2'b00};
      // copy0 skip=0: in 000 -> 0, in 100 -> 1 with a single changed pulse; copy1 idle
      vecs[1]  = '{1'b0, 1'b0, 2'b00, 2'b01, 4'b0000, 6'b111_000, 2'b00, 2'b00, 2'b00};
      vecs[2]  = '{1'b0, 1'b0, 2'b00, 2'b01, 4'b0000, 6'b111_100, 2'b01, 2'b01, 2'b00};
      vecs[3]  = '{1'b0, 1'b0, 2'b00, 2'b01, 4'b0000, 6'b111_100, 2'b01, 2'b00, 2'b00};
      // skip=1: starts 1 and 3 update, 2 and 4 are skipped whatever the inputs
      vecs[4]  = '{1'b0, 1'b1, 2'b00, 2'b01, 4'b0001, 6'b111_001, 2'b00, 2'b00, 2'b00};
      vecs[5]  = '{1'b0, 1'b0, 2'b00, 2'b01, 4'b0001, 6'b111_001, 2'b01, 2'b01, 2'b00};
      vecs[6]  = '{1'b0, 1'b0, 2'b00, 2'b01, 4'b0001, 6'b111_000, 2'b01, 2'b00, 2'b00};
      vecs[7]  = '{1'b0, 1'b0, 2'b00, 2'b01, 4'b0001, 6'b111_000, 2'b00, 2'b01, 2'b00};
      vecs[8]  = '{1'b0, 1'b0, 2'b00, 2'b01, 4'b0001, 6'b111_001, 2'b00, 2'b00, 2'b00};
      // skip=2, reset_nos after the 2nd start clears cnt; copy1 loads init 1
      vecs[9]  = '{1'b0, 1'b1, 2'b00, 2'b00, 4'b0010, 6'b111_001, 2'b00, 2'b00, 2'b00};
      vecs[10] = '{1'b0, 1'b0, 2'b00, 2'b01, 4'b0010, 6'b111_001, 2'b01, 2'b01, 2'b00};
      vecs[11] = '{1'b0, 1'b0, 2'b00, 2'b01, 4'b0010, 6'b111_000, 2'b01, 2'b00, 2'b00};
      vecs[12] = '{1'b0, 1'b1, 2'b10, 2'b01, 4'b0010, 6'b111_001, 2'b10, 2'b00, 2'b00};
      vecs[13] = '{1'b0, 1'b0, 2'b00, 2'b01, 4'b0010, 6'b111_001, 2'b11, 2'b01, 2'b00};
      // skip lowered to 0 mid-count: the running count (2) still drains first
      vecs[14] = '{1'b0, 1'b0, 2'b00, 2'b01, 4'b0000, 6'b111_000, 2'b11, 2'b00, 2'b00};
      vecs[15] = '{1'b0, 1'b0, 2'b00, 2'b01, 4'b0000, 6'b111_000, 2'b11, 2'b00, 2'b00};
      vecs[16] = '{1'b0, 1'b0, 2'b00, 2'b01, 4'b0000, 6'b111_000, 2'b10, 2'b01, 2'b00};
      vecs[17] = '{1'b0, 1'b0, 2'b00, 2'b01, 4'b0000, 6'b111_000, 2'b10, 2'b00, 2'b00};
      // copy1 alone: three unchanged updates assert stable, a flip clears it
      vecs[18] = '{1'b0, 1'b0, 2'b00, 2'b10, 4'b0000, 6'b111_000, 2'b10, 2'b00, 2'b00};
      vecs[19] = '{1'b0, 1'b0, 2'b00, 2'b10, 4'b0000, 6'b111_000, 2'b10, 2'b00, 2'b00};
      vecs[20] = '{1'b0, 1'b0, 2'b00, 2'b10, 4'b0000, 6'b111_000, 2'b10, 2'b00, 2'b10};
      vecs[21] = '{1'b0, 1'b0, 2'b00, 2'b10, 4'b0000, 6'b000_000, 2'b00, 2'b10, 2'b00};
      // rst beats everything; reset_nos with start loads init without updating
      vecs[22] = '{1'b1, 1'b1, 2'b11, 2'b11, 4'b0000, 6'b000_000, 2'b00, 2'b00, 2'b00};
      vecs[23] = '{1'b0, 1'b1, 2'b11, 2'b11, 4'b0000, 6'b000_000, 2'b11, 2'b00, 2'b00};
      vecs[24] = '{1'b0, 1'b0, 2'b00, 2'b11, 4'b0000, 6'b000_000, 2'b00, 2'b11, 2'b00};

      rst = 1'b1; reset_nos = 1'b0; init_state = '0; start = '0; skip = '0; in_states = '0;
      repeat (2) @(posedge clk);
      #1;

      for (int i = 0; i < 25; i++) begin
         drive(vecs[i].rst, vecs[i].rn, vecs[i].init, vecs[i].start, vecs[i].skip, vecs[i].ins);
         check($sformatf("v%0d state", i),   state,   vecs[i].exp_state);
         check($sformatf("v%0d changed", i), changed, vecs[i].exp_changed);
         check($sformatf("v%0d stable", i),  stable,  vecs[i].exp_stable);
         $display("[TB] vec %0d: start=%b ins=%b -> state=%b changed=%b stable=%b",
                  i, vecs[i].start, vecs[i].ins, state, changed, stable);
      end

      // AND rule, inputs 111, init 1: state never flips, stable after 3rd update
      drive(1'b0, 1'b1, 2'b01, 2'b01, 4'b0000, 6'b000_111);
      check("and init state", state_a[0], 1'b1);
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 1'b0, 2'b00, 2'b01, 4'b0000, 6'b000_111);
         check($sformatf("and upd%0d state", k + 1),   state_a[0],   1'b1);
         check($sformatf("and upd%0d changed", k + 1), changed_a[0], 1'b0);
         check($sformatf("and upd%0d stable", k + 1),  stable_a[0],  (k >= 2) ? 1'b1 : 1'b0);
         $display("[TB] and update %0d: state=%b changed=%b stable=%b",
                  k + 1, state_a[0], changed_a[0], stable_a[0]);
      end
      drive(1'b0, 1'b0, 2'b00, 2'b01, 4'b0000, 6'b000_011);
      check("and flip state",   state_a[0],   1'b0);
      check("and flip changed", changed_a[0], 1'b1);
      check("and flip stable",  stable_a[0],  1'b0);
      $display("[TB] and flip: state=%b changed=%b stable=%b", state_a[0], changed_a[0], stable_a[0]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
